// File: rtl/alt_vipitc120_is2vid_timing_gen_if.sv
// Mode and timing bundle for the IS2Vid raster timing generator.
//   slave  : the timing generator. It takes enable, the mode handshake and the
//            mode values, and drives the raster position and timing outputs.
//   master : the mode-calculation stage / formatter side of the same bundle.
interface alt_vipitc120_is2vid_timing_gen_if #(
  parameter int COUNT_W = 16,
  parameter int LINE_W  = 13
);
  logic               enable;
  logic               mode_valid;
  logic               mode_ack;
  logic               interlaced;
  logic [COUNT_W-1:0] h_total_minus_one, v_total_minus_one;
  logic [COUNT_W-1:0] h_blank, h_sync_start, h_sync_end;
  logic [COUNT_W-1:0] f2_v_start, f1_v_start, f1_v_end;
  logic [COUNT_W-1:0] f2_v_sync_start, f2_v_sync_end;
  logic [COUNT_W-1:0] f1_v_sync_start, f1_v_sync_end;
  logic [COUNT_W-1:0] f_rising_edge, f_falling_edge;
  logic [COUNT_W-1:0] ap_line, ap_line_end;
  logic [COUNT_W-1:0] h_count, v_count;
  logic               h_sync, v_sync, h_blank_out, v_blank, de, field, sof;
  logic [LINE_W-1:0]  line_number;
  logic               running;

  modport slave (
    input  enable, mode_valid, interlaced,
           h_total_minus_one, v_total_minus_one, h_blank, h_sync_start,
           h_sync_end, f2_v_start, f1_v_start, f1_v_end, f2_v_sync_start,
           f2_v_sync_end, f1_v_sync_start, f1_v_sync_end, f_rising_edge,
           f_falling_edge, ap_line, ap_line_end,
    output mode_ack, h_count, v_count, h_sync, v_sync, h_blank_out, v_blank,
           de, field, sof, line_number, running
  );

  modport master (
    output enable, mode_valid, interlaced,
           h_total_minus_one, v_total_minus_one, h_blank, h_sync_start,
           h_sync_end, f2_v_start, f1_v_start, f1_v_end, f2_v_sync_start,
           f2_v_sync_end, f1_v_sync_start, f1_v_sync_end, f_rising_edge,
           f_falling_edge, ap_line, ap_line_end,
    input  mode_ack, h_count, v_count, h_sync, v_sync, h_blank_out, v_blank,
           de, field, sof, line_number, running
  );
endinterface

// File: rtl/alt_vipitc120_is2vid_timing_gen.sv
// Free-running raster timing generator for the IS2Vid clocked-video output.
// Mode values are shadow-loaded only at a frame boundary. Horizontal/vertical
// counters then run off the shadow copy and feed registered sync, blank, data
// enable, field and line-number outputs, one cycle behind the counters.
// Ports:
//   clk     : video clock
//   reset_n : asynchronous active-low reset
//   vid     : slave side of the mode/timing bundle (enable, mode handshake,
//             mode values in; counters, timing strobes, line number out)
module alt_vipitc120_is2vid_timing_gen #(
  parameter int COUNT_W = 16,
  parameter int LINE_W  = 13
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  alt_vipitc120_is2vid_timing_gen_if.slave     vid
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  typedef struct packed {
    logic               interlaced;
    logic [COUNT_W-1:0] h_total, v_total, h_blank, hs_start, hs_end;
    logic [COUNT_W-1:0] f2_v_start, f1_v_start, f1_v_end;
    logic [COUNT_W-1:0] f2_vs_start, f2_vs_end, f1_vs_start, f1_vs_end;
    logic [COUNT_W-1:0] f_rise, f_fall, ap_line, ap_line_end;
  } mode_t;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_in;
  logic [COUNT_W-1:0] h_q, h_d, v_q, v_d, v_next;
  logic               field_flop_q, field_flop_d;
  logic               adv, h_last, v_last, frame_end;
  logic               hb, hs, vb, vs;
  logic [LINE_W-1:0]  line_d;
  logic               hs_q, vs_q, hb_q, vb_q, de_q, field_q, sof_q, ack_q, run_q;
  logic [LINE_W-1:0]  line_q;

  assign mode_in = '{interlaced:  vid.interlaced,
                     h_total:     vid.h_total_minus_one,
                     v_total:     vid.v_total_minus_one,
                     h_blank:     vid.h_blank,
                     hs_start:    vid.h_sync_start,
                     hs_end:      vid.h_sync_end,
                     f2_v_start:  vid.f2_v_start,
                     f1_v_start:  vid.f1_v_start,
                     f1_v_end:    vid.f1_v_end,
                     f2_vs_start: vid.f2_v_sync_start,
                     f2_vs_end:   vid.f2_v_sync_end,
                     f1_vs_start: vid.f1_v_sync_start,
                     f1_vs_end:   vid.f1_v_sync_end,
                     f_rise:      vid.f_rising_edge,
                     f_fall:      vid.f_falling_edge,
                     ap_line:     vid.ap_line,
                     ap_line_end: vid.ap_line_end};

  assign adv       = (state_q == RUN) && vid.enable;
  assign h_last    = (h_q == mode_q.h_total);
  assign v_last    = (v_q == mode_q.v_total);
  assign frame_end = adv && h_last && v_last;
  assign v_next    = v_last ? '0 : v_q + ONE;

  // Control: mode_valid outside the frame-end cycle is simply ignored; the
  // requester keeps it high until mode_ack, so it is seen again at frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vid.mode_valid) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (frame_end && vid.mode_valid) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Counters and field flop. With h_total == 0 h_last is always true, so
  // v advances every cycle and the raster still makes progress.
  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    field_flop_d = field_flop_q;
    if (state_q == LOAD) begin
      h_d          = '0;
      v_d          = '0;
      field_flop_d = 1'b0;
    end else if (adv) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_next;
        // Clear is tested first so equal edges leave the field at 0.
        if (v_next == mode_q.f_fall)      field_flop_d = 1'b0;
        else if (v_next == mode_q.f_rise) field_flop_d = 1'b1;
      end else begin
        h_d = h_q + ONE;
      end
    end
  end

  // Decode of the current counter position against the shadow mode.
  always_comb begin
    hb = (h_q < mode_q.h_blank);
    hs = (h_q >= mode_q.hs_start) && (h_q < mode_q.hs_end);
    vb = (v_q >= mode_q.f2_v_start) ||
         (mode_q.interlaced && (v_q >= mode_q.f1_v_start) && (v_q < mode_q.f1_v_end));
    vs = ((v_q >= mode_q.f2_vs_start) && (v_q < mode_q.f2_vs_end)) ||
         (mode_q.interlaced && (v_q >= mode_q.f1_vs_start) && (v_q < mode_q.f1_vs_end));
    line_d = (v_q < mode_q.ap_line_end) ? LINE_W'(v_q + mode_q.ap_line)
                                        : LINE_W'(v_q - mode_q.ap_line_end);
  end

  // Register stage: state, shadow mode, counters and the decoded outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      h_q          <= '0;
      v_q          <= '0;
      field_flop_q <= 1'b0;
      ack_q        <= 1'b0;
      run_q        <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      de_q         <= 1'b0;
      field_q      <= 1'b0;
      sof_q        <= 1'b0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      field_flop_q <= field_flop_d;
      ack_q        <= (state_d == LOAD);
      if (state_d == LOAD) begin
        mode_q <= mode_in;
        run_q  <= 1'b1;
      end
      // Outputs only move while the raster advances; otherwise they hold.
      if (adv) begin
        hs_q    <= hs;
        vs_q    <= vs;
        hb_q    <= hb;
        vb_q    <= vb;
        de_q    <= !hb && !vb;
        field_q <= mode_q.interlaced & field_flop_q;
        sof_q   <= (h_q == '0) && (v_q == '0);
        line_q  <= line_d;
      end
    end
  end

  assign vid.mode_ack    = ack_q;
  assign vid.h_count     = h_q;
  assign vid.v_count     = v_q;
  assign vid.h_sync      = hs_q;
  assign vid.v_sync      = vs_q;
  assign vid.h_blank_out = hb_q;
  assign vid.v_blank     = vb_q;
  assign vid.de          = de_q;
  assign vid.field       = field_q;
  assign vid.sof         = sof_q;
  assign vid.line_number = line_q;
  assign vid.running     = run_q;

endmodule

// File: tb/tb_alt_vipitc120_is2vid_timing_gen.sv
module tb_alt_vipitc120_is2vid_timing_gen;
  localparam int CW = 16;
  localparam int LW = 13;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  alt_vipitc120_is2vid_timing_gen_if #(.COUNT_W(CW), .LINE_W(LW)) vif ();
  alt_vipitc120_is2vid_timing_gen #(.COUNT_W(CW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .vid(vif));

  typedef struct {
    int ilace, ht, vt, hb, hss, hse, f2vs, f1vs, f1ve;
    int f2ss, f2se, f1ss, f1se, fr, ff, apl, ape;
  } mode_t;

  typedef struct {
    int h, v, line;
    bit hs, vs, hb, vb, de, fld, sof, run, ack;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  // reference model: position kept as a linear index within the frame
  int    m_state, m_p;
  bit    m_f;
  mode_t m_sh, drv;
  exp_t  m_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_mode(input mode_t m);
    drv = m;
    vif.interlaced        = m.ilace[0];
    vif.h_total_minus_one = CW'(m.ht);
    vif.v_total_minus_one = CW'(m.vt);
    vif.h_blank           = CW'(m.hb);
    vif.h_sync_start      = CW'(m.hss);
    vif.h_sync_end        = CW'(m.hse);
    vif.f2_v_start        = CW'(m.f2vs);
    vif.f1_v_start        = CW'(m.f1vs);
    vif.f1_v_end          = CW'(m.f1ve);
    vif.f2_v_sync_start   = CW'(m.f2ss);
    vif.f2_v_sync_end     = CW'(m.f2se);
    vif.f1_v_sync_start   = CW'(m.f1ss);
    vif.f1_v_sync_end     = CW'(m.f1se);
    vif.f_rising_edge     = CW'(m.fr);
    vif.f_falling_edge    = CW'(m.ff);
    vif.ap_line           = CW'(m.apl);
    vif.ap_line_end       = CW'(m.ape);
  endtask

  function automatic void model_reset();
    m_state = 0; m_p = 0; m_f = 1'b0;
    m_sh = '{default:0};
    m_o  = '{default:0};
    sbq.delete();
  endfunction

  // Predict the outputs visible after the next rising edge and queue them.
  function automatic void model_step();
    int   hp   = m_sh.ht + 1;
    int   h    = m_p % hp;
    int   v    = m_p / hp;
    bit   adv  = (m_state == 2) && (vif.enable === 1'b1);
    bit   fend = adv && (h == m_sh.ht) && (v == m_sh.vt);
    int   nst  = m_state;
    exp_t e;
    case (m_state)
      0:       if (vif.mode_valid === 1'b1) nst = 1;
      1:       nst = 2;
      default: if (fend && vif.mode_valid === 1'b1) nst = 1;
    endcase
    if (adv) begin
      m_o.hb  = h < m_sh.hb;
      m_o.hs  = (h >= m_sh.hss) && (h < m_sh.hse);
      m_o.vb  = (v >= m_sh.f2vs) || (m_sh.ilace != 0 && v >= m_sh.f1vs && v < m_sh.f1ve);
      m_o.vs  = (v >= m_sh.f2ss && v < m_sh.f2se) ||
                (m_sh.ilace != 0 && v >= m_sh.f1ss && v < m_sh.f1se);
      m_o.de  = !m_o.hb && !m_o.vb;
      m_o.fld = (m_sh.ilace != 0) && m_f;
      m_o.sof = (m_p == 0);
      m_o.line = ((v < m_sh.ape) ? v + m_sh.apl : v - m_sh.ape) % (1 << LW);
    end
    if (m_state == 1) begin
      m_p = 0; m_f = 1'b0;
    end else if (adv) begin
      m_p = fend ? 0 : m_p + 1;
      if (h == hp - 1) begin
        if ((m_p / hp) == m_sh.ff)      m_f = 1'b0;
        else if ((m_p / hp) == m_sh.fr) m_f = 1'b1;
      end
    end
    m_o.ack = (nst == 1);
    if (nst == 1) begin
      m_sh = drv;
      m_o.run = 1'b1;
    end
    m_state = nst;
    e   = m_o;
    e.h = m_p % (m_sh.ht + 1);
    e.v = m_p / (m_sh.ht + 1);
    sbq.push_back(e);
  endfunction

  task automatic cmp(input exp_t e);
    chk("h_count",     32'(vif.h_count),     32'(e.h));
    chk("v_count",     32'(vif.v_count),     32'(e.v));
    chk("h_sync",      32'(vif.h_sync),      32'(e.hs));
    chk("v_sync",      32'(vif.v_sync),      32'(e.vs));
    chk("h_blank_out", 32'(vif.h_blank_out), 32'(e.hb));
    chk("v_blank",     32'(vif.v_blank),     32'(e.vb));
    chk("de",          32'(vif.de),          32'(e.de));
    chk("field",       32'(vif.field),       32'(e.fld));
    chk("sof",         32'(vif.sof),         32'(e.sof));
    chk("line_number", 32'(vif.line_number), 32'(e.line));
    chk("running",     32'(vif.running),     32'(e.run));
    chk("mode_ack",    32'(vif.mode_ack),    32'(e.ack));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cmp(sbq.pop_front());
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (vif.mode_ack !== 1'b1 && n < limit);
    chk("mode_ack_seen", 32'(vif.mode_ack), 32'd1);
    vif.mode_valid = 1'b0;
  endtask

  // Per-frame totals measured from one sof to the next.
  task automatic run_watch(input int cycles, input int period, input int de_f,
                           input int hs_f, input int vb_f, input int fd_f);
    int last = -1;
    int de_c = 0, hs_c = 0, vb_c = 0, fd_c = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (vif.sof === 1'b1) begin
        if (last >= 0) begin
          chk("sof_period",      c - last, period);
          chk("de_per_frame",    de_c, de_f);
          chk("hsync_per_frame", hs_c, hs_f);
          chk("vblank_per_frame", vb_c, vb_f);
          chk("field_per_frame", fd_c, fd_f);
        end
        last = c; de_c = 0; hs_c = 0; vb_c = 0; fd_c = 0;
      end
      de_c += int'(vif.de);
      hs_c += int'(vif.h_sync);
      vb_c += int'(vif.v_blank);
      fd_c += int'(vif.field);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mode_t a, b, c, d;
    exp_t  z;
    int    n, h0, v0, sof_c;
    z = '{default:0};
    a = '{default:0};
    a.ht = 9; a.vt = 5; a.hb = 3; a.hss = 1; a.hse = 2; a.f2vs = 4;
    a.f2ss = 4; a.f2se = 5; a.apl = 1; a.ape = 5;
    b = a; b.ht = 7;
    c = a; c.ilace = 1; c.vt = 11; c.f2vs = 10; c.f1vs = 5; c.f1ve = 6;
    c.f2ss = 10; c.f2se = 11; c.f1ss = 4; c.f1se = 5; c.fr = 6; c.ff = 0; c.ape = 11;
    d = '{default:0};
    d.vt = 3; d.f2vs = 3; d.f2ss = 3; d.f2se = 4; d.ape = 4;

    vif.enable = 1'b1;
    vif.mode_valid = 1'b0;
    drive_mode('{default:0});
    model_reset();
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp(z);
    reset_n = 1'b1;

    // idle without a request: nothing moves
    for (int i = 0; i < 3; i++) step();

    // mode A, progressive 10x6
    drive_mode(a);
    vif.mode_valid = 1'b1;
    wait_ack(10, n);
    chk("ack_latency_idle", n, 1);
    run_watch(130, 60, 28, 6, 20, 0);

    // request mode B mid-frame at v_count == 2
    n = 0;
    while (vif.v_count !== CW'(2) && n < 100) begin step(); n++; end
    chk("reach_v2", 32'(vif.v_count), 32'd2);
    drive_mode(b);
    vif.mode_valid = 1'b1;
    wait_ack(200, n);
    chk("ack_wait_frame_end", n, 40);
    run_watch(100, 48, 20, 6, 16, 0);

    // enable low for 20 cycles mid-line
    n = 0;
    while (vif.h_count !== CW'(4) && n < 20) begin step(); n++; end
    chk("reach_h4", 32'(vif.h_count), 32'd4);
    h0 = int'(vif.h_count);
    v0 = int'(vif.v_count);
    vif.enable = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("hold_h", 32'(vif.h_count), h0);
    chk("hold_v", 32'(vif.v_count), v0);
    vif.enable = 1'b1;
    step();
    chk("resume_h", 32'(vif.h_count), h0 + 1);
    run_watch(100, 48, 20, 6, 16, 0);

    // mode C, interlaced 10x12
    drive_mode(c);
    vif.mode_valid = 1'b1;
    wait_ack(200, n);
    run_watch(250, 120, 63, 12, 30, 60);

    // mode D, degenerate h_total_minus_one == 0
    drive_mode(d);
    vif.mode_valid = 1'b1;
    wait_ack(300, n);
    run_watch(20, 4, 3, 0, 1, 0);

    // asynchronous reset in the middle of a frame
    #3 reset_n = 1'b0;
    #1;
    cmp(z);
    model_reset();
    #2 reset_n = 1'b1;
    sof_c = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      sof_c += int'(vif.sof);
    end
    chk("sof_after_reset", sof_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
